// File: rtl/walkingone_dispatcher_pkg.sv
// Shared constants and types for the walking-one lane dispatcher.
package walkingone_dispatcher_pkg;

  localparam int WIDTH   = 8;
  localparam int LANES   = 3;
  localparam int COUNT_W = 16;
  localparam logic [LANES-1:0] PTR_RST = 3'b001;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic ptr_is_onehot(input logic [LANES-1:0] p);
    return (p == 3'b001) || (p == 3'b010) || (p == 3'b100);
  endfunction

  function automatic logic [LANES-1:0] ptr_rotate(input logic [LANES-1:0] p);
    return {p[LANES-2:0], p[LANES-1]};
  endfunction

endpackage

// File: rtl/walkingone_dispatcher_lane.sv
// One dispatch lane: a held data word plus its full flag.
module dispatcher_lane
  import walkingone_dispatcher_pkg::*;
#(
  parameter int SIZE = WIDTH
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            load,
  input  logic            ack,
  input  logic [SIZE-1:0] data,
  output logic [SIZE-1:0] data_p0,
  output logic            full_p0
);

  // Load only happens on an empty lane, so load and a live ack never collide.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      data_p0 <= '0;
      full_p0 <= 1'b0;
    end else if (load) begin
      data_p0 <= data;
      full_p0 <= 1'b1;
    end else if (ack && full_p0) begin
      full_p0 <= 1'b0;
    end
  end

endmodule

// File: rtl/walkingone_dispatcher.sv
// Round-robin dispatch of source words to three lanes via a walking-one pointer.
module walkingone_dispatcher
  import walkingone_dispatcher_pkg::*;
#(
  parameter int SIZE = WIDTH
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic [SIZE-1:0]    iData,
  input  logic               iValid,
  output logic               oReady,
  input  logic               iRestart,
  input  logic               iDrain,
  output logic [SIZE-1:0]    oLaneData0,
  output logic [SIZE-1:0]    oLaneData1,
  output logic [SIZE-1:0]    oLaneData2,
  output logic [LANES-1:0]   oLaneValid,
  input  logic [LANES-1:0]   iLaneAck,
  output logic [LANES-1:0]   oPointer,
  output logic               oDrained,
  output logic [COUNT_W-1:0] oCount
);

  state_t             state_p0;
  logic [LANES-1:0]   ptr_p0;
  logic [LANES-1:0]   full_p0;
  logic [COUNT_W-1:0] count_p0;
  logic               drained_p0;
  logic [SIZE-1:0]    lane_data_p0 [LANES];
  logic               ptr_ok;
  logic               accept;
  logic [LANES-1:0]   load;

  // Ready depends only on registered state, never on ack/data/valid inputs.
  assign ptr_ok = ptr_is_onehot(ptr_p0);
  assign oReady = (state_p0 == RUN) && ptr_ok && !(|(full_p0 & ptr_p0));
  assign accept = iValid && oReady;
  assign load   = accept ? ptr_p0 : '0;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    dispatcher_lane #(.SIZE(SIZE)) u_lane (
      .Clock   (Clock),
      .Reset   (Reset),
      .load    (load[k]),
      .ack     (iLaneAck[k]),
      .data    (iData),
      .data_p0 (lane_data_p0[k]),
      .full_p0 (full_p0[k])
    );
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_p0   <= RUN;
      ptr_p0     <= PTR_RST;
      count_p0   <= '0;
      drained_p0 <= 1'b0;
    end else begin
      if (!ptr_ok || iRestart) ptr_p0 <= PTR_RST;
      else if (accept)         ptr_p0 <= ptr_rotate(ptr_p0);

      if (accept) count_p0 <= count_p0 + 1'b1;

      drained_p0 <= 1'b0;
      case (state_p0)
        RUN: if (iDrain) state_p0 <= DRAIN;
        DRAIN: begin
          if (full_p0 == '0) begin
            state_p0   <= DONE;
            drained_p0 <= 1'b1;
          end
        end
        DONE:    state_p0 <= iDrain ? DRAIN : RUN;
        default: state_p0 <= RUN;
      endcase
    end
  end

  assign oLaneData0 = lane_data_p0[0];
  assign oLaneData1 = lane_data_p0[1];
  assign oLaneData2 = lane_data_p0[2];
  assign oLaneValid = full_p0;
  assign oPointer   = ptr_p0;
  assign oDrained   = drained_p0;
  assign oCount     = count_p0;

endmodule

// File: tb/tb_walkingone_dispatcher.sv
// Directed bench for walkingone_dispatcher with hand-computed expectations.
module tb_walkingone_dispatcher;
  import walkingone_dispatcher_pkg::*;

  logic               Clock = 1'b0;
  logic               Reset = 1'b1;
  logic [WIDTH-1:0]   iData = '0;
  logic               iValid = 1'b0;
  logic               oReady;
  logic               iRestart = 1'b0;
  logic               iDrain = 1'b0;
  logic [WIDTH-1:0]   oLaneData0, oLaneData1, oLaneData2;
  logic [LANES-1:0]   oLaneValid;
  logic [LANES-1:0]   iLaneAck = '0;
  logic [LANES-1:0]   oPointer;
  logic               oDrained;
  logic [COUNT_W-1:0] oCount;

  int vectors = 0;
  int errors  = 0;

  walkingone_dispatcher dut (
    .Clock(Clock), .Reset(Reset), .iData(iData), .iValid(iValid), .oReady(oReady),
    .iRestart(iRestart), .iDrain(iDrain), .oLaneData0(oLaneData0),
    .oLaneData1(oLaneData1), .oLaneData2(oLaneData2), .oLaneValid(oLaneValid),
    .iLaneAck(iLaneAck), .oPointer(oPointer), .oDrained(oDrained), .oCount(oCount)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    int cycles;

    // Reset state
    tick(); tick();
    Reset = 1'b0;
    tick();
    chk("rst_ptr", 32'(oPointer), 32'h1);
    chk("rst_valid", 32'(oLaneValid), 32'h0);
    chk("rst_count", 32'(oCount), 32'h0);
    chk("rst_ready", 32'(oReady), 32'h1);
    chk("rst_drained", 32'(oDrained), 32'h0);
    chk("rst_lane0", 32'(oLaneData0), 32'h0);

    // Streaming A/B/C with no acks
    iValid = 1'b1; iData = 8'h0A; tick();
    iData = 8'h0B; tick();
    iData = 8'h0C; tick();
    iData = 8'h0D;
    chk("str_lane0", 32'(oLaneData0), 32'h0A);
    chk("str_lane1", 32'(oLaneData1), 32'h0B);
    chk("str_lane2", 32'(oLaneData2), 32'h0C);
    chk("str_valid", 32'(oLaneValid), 32'h7);
    chk("str_ptr", 32'(oPointer), 32'h1);
    chk("str_ready", 32'(oReady), 32'h0);
    chk("str_count", 32'(oCount), 32'h3);

    // Stall/release: ack lane0, 0xD pending
    iLaneAck = 3'b001; tick();
    iLaneAck = 3'b000;
    chk("rel_ready", 32'(oReady), 32'h1);
    chk("rel_valid", 32'(oLaneValid), 32'h6);
    chk("rel_count_hold", 32'(oCount), 32'h3);
    tick();
    iValid = 1'b0;
    chk("rel_lane0", 32'(oLaneData0), 32'h0D);
    chk("rel_ptr", 32'(oPointer), 32'h2);
    chk("rel_count", 32'(oCount), 32'h4);
    chk("rel_ready_after", 32'(oReady), 32'h0);

    // Drain with lanes 1 and 2 full; source keeps offering a word
    iLaneAck = 3'b001; tick();
    chk("drn_valid_pre", 32'(oLaneValid), 32'h6);
    iLaneAck = 3'b000; iDrain = 1'b1; iValid = 1'b1; iData = 8'hEE; tick();
    chk("drn_ready_e7", 32'(oReady), 32'h0);
    chk("drn_pulse_e7", 32'(oDrained), 32'h0);
    iLaneAck = 3'b010; tick();
    chk("drn_ready_e8", 32'(oReady), 32'h0);
    chk("drn_pulse_e8", 32'(oDrained), 32'h0);
    chk("drn_valid_e8", 32'(oLaneValid), 32'h4);
    iLaneAck = 3'b100; tick();
    chk("drn_ready_e9", 32'(oReady), 32'h0);
    chk("drn_pulse_e9", 32'(oDrained), 32'h0);
    chk("drn_valid_e9", 32'(oLaneValid), 32'h0);
    iLaneAck = 3'b000; iDrain = 1'b0; iValid = 1'b0; tick();
    chk("drn_pulse_e10", 32'(oDrained), 32'h1);
    chk("drn_ready_e10", 32'(oReady), 32'h0);
    tick();
    chk("drn_pulse_e11", 32'(oDrained), 32'h0);
    chk("drn_ready_run", 32'(oReady), 32'h1);
    chk("drn_count", 32'(oCount), 32'h4);
    chk("drn_lane0_kept", 32'(oLaneData0), 32'h0D);

    // Restart coinciding with an accepted word at pointer 100
    iValid = 1'b1; iData = 8'h11; tick();
    chk("rs_lane1", 32'(oLaneData1), 32'h11);
    chk("rs_ptr_pre", 32'(oPointer), 32'h4);
    iData = 8'h55; iRestart = 1'b1; tick();
    iRestart = 1'b0;
    chk("rs_lane2", 32'(oLaneData2), 32'h55);
    chk("rs_ptr", 32'(oPointer), 32'h1);
    chk("rs_count", 32'(oCount), 32'h6);
    chk("rs_valid", 32'(oLaneValid), 32'h6);

    // Stream with all acks held until the count reaches 0xFFFF
    iLaneAck = 3'b111; iData = 8'h33;
    cycles = 0;
    while (oCount !== 16'hFFFF && cycles < 70000) begin
      tick();
      cycles++;
    end
    chk("wrap_reached", 32'(oCount), 32'hFFFF);
    chk("wrap_ptr_pre", 32'(oPointer), 32'h1);
    chk("wrap_ready_pre", 32'(oReady), 32'h1);
    iLaneAck = 3'b000; iData = 8'h77; tick();
    iValid = 1'b0;
    chk("wrap_count", 32'(oCount), 32'h0);
    chk("wrap_ptr", 32'(oPointer), 32'h2);
    chk("wrap_lane0", 32'(oLaneData0), 32'h77);
    iLaneAck = 3'b111; tick();
    chk("clr_valid", 32'(oLaneValid), 32'h0);
    tick();
    iLaneAck = 3'b000;
    chk("spur_valid", 32'(oLaneValid), 32'h0);
    chk("spur_count", 32'(oCount), 32'h0);
    chk("spur_ptr", 32'(oPointer), 32'h2);
    chk("spur_lane0", 32'(oLaneData0), 32'h77);
    chk("spur_ready", 32'(oReady), 32'h1);

    // Fill all lanes, then asynchronous reset mid-cycle
    iValid = 1'b1; iData = 8'h21; tick();
    iData = 8'h22; tick();
    iData = 8'h23; tick();
    iValid = 1'b0;
    chk("ar_valid_pre", 32'(oLaneValid), 32'h7);
    chk("ar_lane0_pre", 32'(oLaneData0), 32'h23);
    chk("ar_count_pre", 32'(oCount), 32'h3);
    #3 Reset = 1'b1;
    #1;
    chk("ar_valid", 32'(oLaneValid), 32'h0);
    chk("ar_ptr", 32'(oPointer), 32'h1);
    chk("ar_count", 32'(oCount), 32'h0);
    chk("ar_lane0", 32'(oLaneData0), 32'h0);
    chk("ar_lane1", 32'(oLaneData1), 32'h0);
    chk("ar_lane2", 32'(oLaneData2), 32'h0);
    chk("ar_drained", 32'(oDrained), 32'h0);
    tick();
    Reset = 1'b0;
    tick();
    chk("ar_drained_post", 32'(oDrained), 32'h0);
    iValid = 1'b1; iData = 8'h99; tick();
    iValid = 1'b0;
    chk("ar_first_lane0", 32'(oLaneData0), 32'h99);
    chk("ar_first_ptr", 32'(oPointer), 32'h2);
    chk("ar_first_count", 32'(oCount), 32'h1);
    chk("ar_first_drained", 32'(oDrained), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
